// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB4 register-memory completer.
// The write-protect feature itself is switched by APB_SLV_WPROT_EN in apb_slave_mem.
package apb_slv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } apb_slv_state_e;

   // Protected region starts at DEPTH*(FRAC-1)/FRAC, i.e. the top quarter.
   localparam int WPROT_BASE_FRAC = 4;
   localparam int MAX_WAIT        = 15;

   function automatic int cntWidth(input int waitCycles);
      int w;
      w = $clog2(waitCycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/apb_slv_ram.sv
// Word-organised storage with byte-lane writes, combinational read and
// asynchronous clear of every word.
module apb_slv_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int IDX_W      = 6,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      idx_i,
   input  logic [STRB_WIDTH-1:0] strb_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mergedWord;
   logic                  idxValid;

   assign idxValid = ({1'b0, idx_i} < DEPTH_LIM);
   assign rdata_o  = idxValid ? mem_q[idx_i] : '0;

   // Merge the strobed lanes into the current word so a single full-word
   // store happens per write.
   always_comb begin
      mergedWord = rdata_o;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (strb_i[b]) begin
            mergedWord[b*8 +: 8] = wdata_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
      end else if (we_i && idxValid) begin
         mem_q[idx_i] <= mergedWord;
      end
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer fronting apb_slv_ram: setup latch, wait-state counter, decode
// and registered response. Define APB_SLV_WPROT_EN to make the top quarter read-only.
module apb_slave_mem
   import apb_slv_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [STRB_WIDTH-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int OFFS_W   = $clog2(STRB_WIDTH);
   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
   localparam int CNT_W    = cntWidth(WAIT_EFF);
   localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'((WAIT_EFF > 0) ? WAIT_EFF - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   apb_slv_state_e        state_q, state_d;
   logic [CNT_W-1:0]      waitCnt_q, waitCnt_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] strb_q, strb_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;

   logic                  curWrite;
   logic [ADDR_WIDTH-1:0] curAddr;
   logic [DATA_WIDTH-1:0] curWdata;
   logic [STRB_WIDTH-1:0] curStrb;
   logic [ADDR_WIDTH-1:0] wordIdx;
   logic                  misaligned, outOfRange, wprotHit, accessErr;
   logic                  respond, ramWe;
   logic [DATA_WIDTH-1:0] ramRdata;

   // With zero wait states the response is registered at the end of setup,
   // so decode must see the live bus there instead of the latched copy.
   assign curWrite = (state_q == IDLE) ? PWRITE : write_q;
   assign curAddr  = (state_q == IDLE) ? PADDR  : addr_q;
   assign curWdata = (state_q == IDLE) ? PWDATA : wdata_q;
   assign curStrb  = (state_q == IDLE) ? PSTRB  : strb_q;

   assign wordIdx    = curAddr >> OFFS_W;
   assign misaligned = |(curAddr & ADDR_MASK);
   assign outOfRange = ({1'b0, wordIdx} >= DEPTH_LIM);

`ifdef APB_SLV_WPROT_EN
   localparam int WPROT_BASE = DEPTH * (WPROT_BASE_FRAC - 1) / WPROT_BASE_FRAC;
   localparam logic [ADDR_WIDTH:0] WPROT_LIM = (ADDR_WIDTH + 1)'(WPROT_BASE);
   assign wprotHit = curWrite && ({1'b0, wordIdx} >= WPROT_LIM);
`else
   assign wprotHit = 1'b0;
`endif

   assign accessErr = misaligned | outOfRange | wprotHit;

   // Register every output and the transfer context; reset aborts any transfer.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Next-state logic; response outputs default low so PREADY is a one-cycle pulse.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      respond   = 1'b0;
      ramWe     = 1'b0;

      case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               write_d = PWRITE;
               addr_d  = PADDR;
               wdata_d = PWDATA;
               strb_d  = PSTRB;
               if (WAIT_EFF == 0) begin
                  respond = 1'b1;
               end else begin
                  waitCnt_d = CNT_LOAD;
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            if (!PSEL || !PENABLE) begin
               state_d = IDLE;
            end else if (waitCnt_q != '0) begin
               waitCnt_d = waitCnt_q - CNT_W'(1);
            end else begin
               respond = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (respond) begin
         state_d   = RESP;
         waitCnt_d = '0;
         pready_d  = 1'b1;
         pslverr_d = accessErr;
         prdata_d  = (curWrite || accessErr) ? '0 : ramRdata;
         ramWe     = curWrite && !accessErr;
      end
   end

   apb_slv_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) uRam (
      .clk_i   (PCLK),
      .rst_ni  (PRESETn),
      .we_i    (ramWe),
      .idx_i   (wordIdx[IDX_W-1:0]),
      .strb_i  (curStrb),
      .wdata_i (curWdata),
      .rdata_o (ramRdata)
   );

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a zero-wait 128-word instance and a
// three-wait 64-word instance share the bus, each with its own select.
module tb_apb_slave_mem;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          psel0, psel3, PENABLE, PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [SW-1:0] PSTRB;
   logic [DW-1:0] prdata0, prdata3;
   logic          pready0, pready3, pslverr0, pslverr3;

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(128), .WAIT_CYCLES(0)) dut0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
   );

   apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .WAIT_CYCLES(3)) dut3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
   );

   // One APB transfer; returns at the negedge where PREADY is seen high,
   // leaving the bus asserted so another transfer can follow immediately.
   task automatic doXfer(input bit useDut3, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                         output logic [DW-1:0] rdata, output logic err, output int waits);
      logic rdy;
      @(negedge PCLK);
      psel0 = !useDut3; psel3 = useDut3;
      PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
      @(negedge PCLK);
      PENABLE = 1'b1;
      waits = 0; rdata = '0; err = 1'b0;
      rdy = useDut3 ? pready3 : pready0;
      while (rdy !== 1'b1 && waits < 40) begin
         waits++;
         @(negedge PCLK);
         rdy = useDut3 ? pready3 : pready0;
      end
      if (rdy !== 1'b1) begin
         checks++; errors++;
         $display("[TB] FAIL timeout addr=%h: no PREADY after %0d cycles, required within 16", addr, waits);
      end else begin
         rdata = useDut3 ? prdata3 : prdata0;
         err   = useDut3 ? pslverr3 : pslverr0;
      end
   endtask

   task automatic busIdle();
      @(negedge PCLK);
      psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
      PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = '0;
      repeat (2) @(negedge PCLK);
      checks++; if (pready0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pready0: got %b expected 0", pready0); end
      checks++; if (pslverr0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pslverr0: got %b expected 0", pslverr0); end
      checks++; if (prdata0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_prdata0: got %h expected 0", prdata0); end
      checks++; if (pready3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pready3: got %b expected 0", pready3); end
      PRESETn = 1'b1;
   endtask

   task automatic test_basic();
      logic [DW-1:0] rd; logic err; int w;
      doXfer(0, 1, 12'h100, 32'hDEADBEEF, 4'hF, rd, err, w);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL basic_wr_err: got %b expected 0", err); end
      checks++; if (w != 0) begin errors++; $display("[TB] FAIL basic_wr_waits: got %0d expected 0", w); end
      doXfer(0, 0, 12'h100, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL basic_rd_data: got %h expected deadbeef", rd); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL basic_rd_err: got %b expected 0", err); end
      checks++; if (w != 0) begin errors++; $display("[TB] FAIL basic_rd_waits: got %0d expected 0", w); end
      @(negedge PCLK);
      checks++; if (pready0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_pready_pulse: got %b expected 0", pready0); end
      checks++; if (prdata0 !== 32'h0) begin errors++; $display("[TB] FAIL basic_prdata_clear: got %h expected 0", prdata0); end
      psel0 = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_strobe();
      logic [DW-1:0] rd; logic err; int w;
      doXfer(0, 1, 12'h010, 32'hFFFFFFFF, 4'hF, rd, err, w);
      doXfer(0, 1, 12'h010, 32'h11223344, 4'h5, rd, err, w);
      doXfer(0, 0, 12'h010, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'hFF22FF44) begin errors++; $display("[TB] FAIL strobe_merge: got %h expected ff22ff44", rd); end
      doXfer(0, 1, 12'h010, 32'h00000000, 4'h0, rd, err, w);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL zero_strobe_err: got %b expected 0", err); end
      doXfer(0, 0, 12'h010, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'hFF22FF44) begin errors++; $display("[TB] FAIL zero_strobe_keep: got %h expected ff22ff44", rd); end
      busIdle();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] rd; logic err; int w;
      doXfer(0, 1, 12'h020, 32'hA5A5A5A5, 4'hF, rd, err, w);
      doXfer(0, 0, 12'h020, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL b2b_rd: got %h expected a5a5a5a5", rd); end
      checks++; if (w != 0) begin errors++; $display("[TB] FAIL b2b_waits: got %0d expected 0", w); end
      doXfer(0, 0, 12'h024, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL b2b_unwritten: got %h expected 0", rd); end
      doXfer(0, 1, 12'h1FC, 32'h0BADF00D, 4'hF, rd, err, w);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL last_word_wr_err: got %b expected 0", err); end
      doXfer(0, 0, 12'h1FC, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL last_word_rd: got %h expected 0badf00d", rd); end
      doXfer(0, 0, 12'h200, 32'h0, 4'h0, rd, err, w);
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL past_depth_err: got %b expected 1", err); end
      busIdle();
   endtask

   task automatic test_wait();
      logic [DW-1:0] rd; logic err; int w;
      doXfer(1, 1, 12'h004, 32'h12345678, 4'hF, rd, err, w);
      checks++; if (w != 3) begin errors++; $display("[TB] FAIL wait_wr_cycles: got %0d expected 3", w); end
      doXfer(1, 0, 12'h004, 32'h0, 4'h0, rd, err, w);
      checks++; if (w != 3) begin errors++; $display("[TB] FAIL wait_rd_cycles: got %0d expected 3", w); end
      checks++; if (rd !== 32'h12345678) begin errors++; $display("[TB] FAIL wait_rd_data: got %h expected 12345678", rd); end
      @(negedge PCLK);
      checks++; if (pready3 !== 1'b0) begin errors++; $display("[TB] FAIL wait_pready_pulse: got %b expected 0", pready3); end
      psel3 = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_errors();
      logic [DW-1:0] rd; logic err; int w;
      doXfer(1, 1, 12'h000, 32'hCAFEF00D, 4'hF, rd, err, w);
      doXfer(1, 0, 12'h100, 32'h0, 4'h0, rd, err, w);
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL oor_rd_err: got %b expected 1", err); end
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL oor_rd_data: got %h expected 0", rd); end
      doXfer(1, 1, 12'h002, 32'hFFFFFFFF, 4'hF, rd, err, w);
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL misalign_wr_err: got %b expected 1", err); end
      @(negedge PCLK);
      checks++; if (pslverr3 !== 1'b0) begin errors++; $display("[TB] FAIL pslverr_pulse: got %b expected 0", pslverr3); end
      doXfer(1, 0, 12'h000, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL misalign_no_write: got %h expected cafef00d", rd); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL word0_rd_err: got %b expected 0", err); end
      doXfer(1, 0, 12'h001, 32'h0, 4'h0, rd, err, w);
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL misalign_rd_err: got %b expected 1", err); end
      busIdle();
   endtask

   task automatic test_abort();
      logic [DW-1:0] rd; logic err; int w; int seen;
      @(negedge PCLK);
      psel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h030; PWDATA = 32'h00000077; PSTRB = 4'hF;
      @(negedge PCLK); PENABLE = 1'b1;
      @(negedge PCLK); psel3 = 1'b0; PENABLE = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge PCLK);
         if (pready3 !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_pready: got %0d high cycles expected 0", seen); end
      doXfer(1, 0, 12'h030, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL abort_no_write: got %h expected 0", rd); end
      busIdle();
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] rd; logic err; int w;
      doXfer(1, 1, 12'h020, 32'h55555555, 4'hF, rd, err, w);
      busIdle();
      @(negedge PCLK);
      psel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h020; PWDATA = 32'h99999999; PSTRB = 4'hF;
      @(negedge PCLK); PENABLE = 1'b1;
      @(negedge PCLK);
      PRESETn = 1'b0;
      #1;
      checks++; if (pready3 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pready: got %b expected 0", pready3); end
      psel3 = 1'b0; PENABLE = 1'b0;
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      doXfer(1, 0, 12'h020, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_mem_clear: got %h expected 0", rd); end
      doXfer(0, 0, 12'h100, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_dut0_clear: got %h expected 0", rd); end
      busIdle();
   endtask

   task automatic test_wprot();
      logic [DW-1:0] rd; logic err; int w;
      doXfer(1, 1, 12'h0C8, 32'h5A5A5A5A, 4'hF, rd, err, w);
`ifdef APB_SLV_WPROT_EN
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL wprot_wr_err: got %b expected 1", err); end
      doXfer(1, 0, 12'h0C8, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL wprot_rd_data: got %h expected 0", rd); end
`else
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL w50_wr_err: got %b expected 0", err); end
      doXfer(1, 0, 12'h0C8, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL w50_rd_data: got %h expected 5a5a5a5a", rd); end
`endif
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL w50_rd_err: got %b expected 0", err); end
      doXfer(1, 1, 12'h0BC, 32'h47474747, 4'hF, rd, err, w);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL w47_wr_err: got %b expected 0", err); end
      doXfer(1, 0, 12'h0BC, 32'h0, 4'h0, rd, err, w);
      checks++; if (rd !== 32'h47474747) begin errors++; $display("[TB] FAIL w47_rd_data: got %h expected 47474747", rd); end
      busIdle();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_strobe();
      test_back_to_back();
      test_wait();
      test_errors();
      test_abort();
      test_reset_mid();
      test_wprot();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
